reg_dump: RTL and testbench
===========================

// Module: reg_dump
// PURPOSE
//  Read-side debug streamer for the RV32I register file. On a start pulse it
//  walks register addresses 0..NREGS-1 through one register-file read port.
//  It waits out the port's fixed read latency, captures each value and
//  streams it out on a valid/ready interface. Sits beside the core, owning a
//  spare read port, and feeds the debug/trace path and the testbench scoreboard.
// PARAMETERS
//  NREGS   32  registers dumped, indices 0..NREGS-1 (NREGS >= 2)
//  AW      5   register address width, 2**AW >= NREGS
//  DW      32  register data width
//  RD_LAT  1   cycles from rf_addr stable to rf_rdata valid (1..4)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   begin dump; sampled only in IDLE
//  abort      in   1   synchronous cancel of a dump in progress
//  rf_addr    out  AW  read address to register file
//  rf_rdata   in   DW  read data from register file
//  out_valid  out  1   out_data holds a dumped word
//  out_ready  in   1   sink accepts word when out_valid & out_ready
//  out_data   out  DW  dumped word
//  out_index  out  AW  register index of out_data
//  out_last   out  1   qualifies final word of the dump
//  busy       out  1   high in any state other than IDLE
//  done       out  1   one-cycle pulse after final word accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, idx=0, lat=0. All outputs 0:
//   rf_addr, out_*, busy, done. Effect is immediate, mid-dump included.
//  rf_addr is a register and always equals idx.
//  States:
//   IDLE  - start=1: idx<=0, lat<=RD_LAT, ->ISSUE. Else hold.
//   ISSUE - lat counts down to 0; on the edge where lat==0, capture
//           out_data<=rf_rdata, out_index<=idx, ->SEND. rf_rdata is sampled
//           RD_LAT+1 edges after rf_addr changed.
//   SEND  - out_valid=1. out_data, out_index, out_last and rf_addr are held
//           stable while out_ready=0.
//           On handshake with idx==NREGS-1: ->IDLE and pulse done (or ->CSUM).
//           On handshake otherwise: idx<=idx+1, lat<=RD_LAT, ->ISSUE.
//  Throughput: RD_LAT+2 cycles per word with out_ready tied high.
//  out_last=1 only while SEND with idx==NREGS-1 (CSUM: see CONFIGURATION).
//  done asserts the cycle after the final handshake, for exactly 1 cycle.
//  abort=1 in ISSUE/SEND/CSUM: next edge ->IDLE, out_valid=0, idx=0, no done.
//   abort beats a coincident handshake. abort in IDLE has no effect.
//  start while busy: ignored. start and abort together in IDLE: start wins.
//  idx never exceeds NREGS-1 and never wraps. A new dump always restarts at 0.
//  rf_rdata is not checked. Register 0 is dumped as read (0 from a correct file).
// CONFIGURATION
//  REG_DUMP_CHKSUM_EN defined: an accumulator XORs every captured word
//   (cleared on start). After the NREGS-1 handshake, ->CSUM: out_valid=1,
//   out_data=XOR, out_index=0, out_last=1 (moved off the NREGS-1 word).
//   CSUM handshake ->IDLE and pulses done. Dump is NREGS+1 words.
//  Not defined: no accumulator, no CSUM state. Dump is NREGS words and
//   out_last is on word NREGS-1.
// TESTING
//  1. Preload x1..x31=0x100+i, x0=0, out_ready=1, start -> 32 words
//     0,0x101..0x11F; out_index 0..31; out_last on 0x11F; done 1 cycle;
//     96 cycles start->last handshake.
//  2. Same preload; out_ready=0 for 5 cycles at index 3 -> out_data=0x103
//     and rf_addr=3 held stable; no word lost or duplicated.
//  3. start pulsed at index 7 -> ignored. abort at index 10 -> out_valid=0
//     next cycle, no done. Restart -> first word index 0.
//  4. rst_n low mid-SEND at index 20 -> all outputs 0 same cycle; release,
//     start -> clean full dump.
//  5. REG_DUMP_CHKSUM_EN, preload as 1 -> 33rd word = XOR of x0..x31,
//     out_index 0, out_last only on it.
//  6. RD_LAT=2 model -> data matches, 4 cycles/word, sample at addr+3 edges.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: read-side debug streamer for the RV32I register file.
// It walks register addresses 0..NREGS-1 through one read port. For each
// address it waits out the fixed read latency, captures the value and
// streams it out on a valid/ready interface.
// Optional feature macro: REG_DUMP_CHKSUM_EN. When defined, the dump gets a
// trailing word holding the XOR of all captured words.
module reg_dump #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned    LW       = $clog2(RD_LAT + 1);
    localparam logic [AW-1:0]  LAST_IDX = AW'(NREGS - 1);
    localparam logic [LW-1:0]  LAT_INIT = LW'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2
`ifdef REG_DUMP_CHKSUM_EN
        ,
        CSUM  = 2'd3
`endif
    } state_t;

    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic [LW-1:0] lat_q;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] index_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;
`ifdef REG_DUMP_CHKSUM_EN
    logic [DW-1:0] acc_q;
`endif

    // Dump sequencer: address walk, latency wait, capture and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REG_DUMP_CHKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Cancel wins over any coincident handshake; no done pulse.
                state_q <= IDLE;
                idx_q   <= '0;
                lat_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            idx_q   <= '0;
                            lat_q   <= LAT_INIT;
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
`ifdef REG_DUMP_CHKSUM_EN
                            acc_q   <= '0;
`endif
                        end
                    end
                    ISSUE: begin
                        if (lat_q == '0) begin
                            data_q  <= rf_rdata;
                            index_q <= idx_q;
                            valid_q <= 1'b1;
                            state_q <= SEND;
`ifdef REG_DUMP_CHKSUM_EN
                            last_q  <= 1'b0;
                            acc_q   <= acc_q ^ rf_rdata;
`else
                            last_q  <= (idx_q == LAST_IDX);
`endif
                        end else begin
                            lat_q <= lat_q - LW'(1);
                        end
                    end
                    SEND: begin
                        if (out_ready) begin
                            if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHKSUM_EN
                                // Trailing checksum word carries the last flag.
                                data_q  <= acc_q;
                                index_q <= '0;
                                last_q  <= 1'b1;
                                state_q <= CSUM;
`else
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
`endif
                            end else begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                idx_q   <= idx_q + AW'(1);
                                lat_q   <= LAT_INIT;
                                state_q <= ISSUE;
                            end
                        end
                    end
`ifdef REG_DUMP_CHKSUM_EN
                    CSUM: begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_addr   = idx_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Testbench for reg_dump: two instances (read latency 1 and 2) share the
// control inputs; each has its own register-file latency model and its own
// expected-word queue. REG_DUMP_CHKSUM_EN selects the trailing checksum word.
module tb_reg_dump;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
`ifdef REG_DUMP_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, out_ready;

    logic [AW-1:0] a1, a2, i1, i2;
    logic [DW-1:0] rd1, rd2, s2, d1, d2;
    logic v1, v2, l1, l2, b1, b2, dn1, dn2;

    logic [DW-1:0] mem [NREGS];
    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   last_hs [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file models: RD_LAT pipeline stages from address to data.
    always @(posedge clk) rd1 <= mem[a1];
    always @(posedge clk) begin
        s2  <= mem[a2];
        rd2 <= s2;
    end

    reg_dump #(.NREGS(NREGS), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rf_addr(a1), .rf_rdata(rd1), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_index(i1), .out_last(l1), .busy(b1), .done(dn1)
    );

    reg_dump #(.NREGS(NREGS), .AW(AW), .DW(DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rf_addr(a2), .rf_rdata(rd2), .out_valid(v2), .out_ready(out_ready),
        .out_data(d2), .out_index(i2), .out_last(l2), .busy(b2), .done(dn2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Consume one accepted word from instance d and compare with the queue head.
    task automatic mon(input int d, input logic v, input logic [DW-1:0] dat,
                       input logic [AW-1:0] ix, input logic lst);
        exp_t e;
        int   sz;
        if (rst_n && v && out_ready && !abort) begin
            sz = (d == 0) ? q0.size() : q1.size();
            chk($sformatf("d%0d_word_expected", d), 32'(sz > 0), 32'd1);
            if (sz > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (d != 0) void'(q1.size());
                chk($sformatf("d%0d_data", d), dat, e.data);
                chk($sformatf("d%0d_index", d), 32'(ix), 32'(e.idx));
                chk($sformatf("d%0d_last", d), 32'(lst), 32'(e.last));
            end
            if (lst) last_hs[d] = cyc + 1;
        end
    endtask

    always @(negedge clk) begin
        #1;
        mon(0, v1, d1, i1, l1);
        mon(1, v2, d2, i2, l2);
    end

    // Pulse start for one edge and queue the expected dump for both instances.
    task automatic start_dump();
        exp_t          e;
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            e.data = mem[i];
            e.idx  = AW'(i);
            e.last = (i == int'(NREGS) - 1) && (CHK == 0);
            x      = x ^ mem[i];
            q0.push_back(e);
            q1.push_back(e);
        end
        if (CHK != 0) begin
            e.data = x;
            e.idx  = '0;
            e.last = 1'b1;
            q0.push_back(e);
            q1.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idx(input string tag, input logic [AW-1:0] ix);
        int n = 0;
        while (!(v1 && i1 == ix) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!b1 && !b2 && q0.size() == 0 && q1.size() == 0) && n < 1000);
        chk({tag, "_finished"}, 32'(n < 1000), 32'd1);
        chk({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
        chk({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < int'(NREGS); i++)
            mem[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        last_hs[0] = 0;
        last_hs[1] = 0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_addr",  32'(a1), 32'd0);
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_data",  d1,      32'd0);
        chk("rst_index", 32'(i1), 32'd0);
        chk("rst_last",  32'(l1), 32'd0);
        chk("rst_busy",  32'(b1), 32'd0);
        chk("rst_done",  32'(dn1), 32'd0);
        chk("rst_valid2", 32'(v2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full dump, ready high, throughput and done pulse.
        start_dump();
        chk("t1_busy", 32'(b1), 32'd1);
        n = 0;
        while (!(v1 && l1 && out_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t1_last_seen", 32'(n < 400), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(dn1), 32'd1);
        chk("t1_busy_after", 32'(b1), 32'd0);
        @(negedge clk);
        chk("t1_done_clear", 32'(dn1), 32'd0);
        wait_end("t1");
        chk("t1_cycles_lat1", 32'(last_hs[0] - t0), 32'(3 * NREGS + CHK));
        chk("t1_cycles_lat2", 32'(last_hs[1] - t0), 32'(4 * NREGS + CHK));

        // 2: backpressure at index 3 for 5 cycles.
        start_dump();
        wait_idx("t2", 5'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 32'(v1), 32'd1);
            chk("t2_hold_data",  d1,      32'h103);
            chk("t2_hold_addr",  32'(a1), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_end("t2");

        // 3: start while busy ignored, abort, restart from index 0.
        start_dump();
        wait_idx("t3_i7", 5'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx("t3_i10", 5'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_abort_valid", 32'(v1), 32'd0);
        chk("t3_abort_busy",  32'(b1), 32'd0);
        chk("t3_abort_addr",  32'(a1), 32'd0);
        chk("t3_abort_done",  32'(dn1), 32'd0);
        chk("t3_abort_busy2", 32'(b2), 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("t3_no_done", 32'(dn1 | dn2), 32'd0);
        start_dump();
        wait_end("t3");

        // 4: asynchronous reset mid-SEND at index 20, then a clean dump.
        start_dump();
        wait_idx("t4", 5'd20);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_addr",  32'(a1), 32'd0);
        chk("t4_rst_valid", 32'(v1), 32'd0);
        chk("t4_rst_data",  d1,      32'd0);
        chk("t4_rst_index", 32'(i1), 32'd0);
        chk("t4_rst_last",  32'(l1), 32'd0);
        chk("t4_rst_busy",  32'(b1), 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_dump();
        wait_end("t4");
        chk("t4_cycles_lat1", 32'(last_hs[0] - t0), 32'(3 * NREGS + CHK));
        chk("t4_cycles_lat2", 32'(last_hs[1] - t0), 32'(4 * NREGS + CHK));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
